// File: rtl/vrf_wb_arbiter.sv
// Writeback arbiter in front of the vector register file: per-source FIFOs drained
// round-robin onto registered write ports, never two writes to one register per cycle.
module vrf_wb_arbiter #(
  parameter int NUM_SRC      = 4,
  parameter int NUM_WR_PORTS = 8,
  parameter int NUM_REG      = 32,
  parameter int DATA_SIZE    = 2048,
  parameter int FIFO_DEPTH   = 4,
  localparam int ADDRESS     = $clog2(NUM_REG)
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic [NUM_SRC-1:0]       src_valid,
  output logic [NUM_SRC-1:0]       src_ready,
  input  logic [ADDRESS-1:0]       src_addr [NUM_SRC],
  input  logic [DATA_SIZE-1:0]     src_data [NUM_SRC],
  input  logic [DATA_SIZE/8-1:0]   src_strb [NUM_SRC],
  output logic [NUM_WR_PORTS-1:0]  wr_en,
  output logic [ADDRESS-1:0]       wr_addr [NUM_WR_PORTS],
  output logic [DATA_SIZE-1:0]     wr_data [NUM_WR_PORTS],
  output logic [DATA_SIZE/8-1:0]   wr_strb [NUM_WR_PORTS],
  output logic                     idle
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int PW    = (NUM_WR_PORTS > 1) ? $clog2(NUM_WR_PORTS) : 1;
  localparam int SB    = DATA_SIZE / 8;

  logic [ADDRESS-1:0]   mem_addr [NUM_SRC][FIFO_DEPTH];
  logic [DATA_SIZE-1:0] mem_data [NUM_SRC][FIFO_DEPTH];
  logic [SB-1:0]        mem_strb [NUM_SRC][FIFO_DEPTH];

  logic [PTR_W-1:0]     rd_ptr [NUM_SRC];
  logic [PTR_W-1:0]     wr_ptr [NUM_SRC];
  logic [CNT_W-1:0]     count  [NUM_SRC];

  logic [ADDRESS-1:0]   head_addr [NUM_SRC];
  logic [DATA_SIZE-1:0] head_data [NUM_SRC];
  logic [SB-1:0]        head_strb [NUM_SRC];

  logic [NUM_SRC-1:0]   full, nonempty, push, grant;
  logic [SRC_W-1:0]     rr_ptr, rr_next;

  logic [NUM_WR_PORTS-1:0] port_vld;
  logic [ADDRESS-1:0]      port_addr [NUM_WR_PORTS];
  logic [DATA_SIZE-1:0]    port_data [NUM_WR_PORTS];
  logic [SB-1:0]           port_strb [NUM_WR_PORTS];

  logic [SRC_W:0]       scan_sum;
  logic [SRC_W-1:0]     scan_idx;
  logic [PW:0]          n_gnt;
  logic                 clash;

  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      full[s]      = (count[s] == CNT_W'(FIFO_DEPTH));
      nonempty[s]  = (count[s] != '0);
      head_addr[s] = mem_addr[s][rd_ptr[s]];
      head_data[s] = mem_data[s][rd_ptr[s]];
      head_strb[s] = mem_strb[s][rd_ptr[s]];
    end
  end

  // Ready comes only from registered occupancy, so a full FIFO refuses even when popping.
  assign src_ready = ~full;
  assign push      = src_valid & ~full;

  // Scan from rr_ptr; the k-th grant lands on port k. Skipped heads stay for a later cycle.
  always_comb begin
    grant    = '0;
    port_vld = '0;
    rr_next  = rr_ptr;
    n_gnt    = '0;
    scan_sum = '0;
    scan_idx = '0;
    clash    = 1'b0;
    for (int p = 0; p < NUM_WR_PORTS; p++) begin
      port_addr[p] = '0;
      port_data[p] = '0;
      port_strb[p] = '0;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      scan_sum = {1'b0, rr_ptr} + (SRC_W+1)'(i);
      if (scan_sum >= (SRC_W+1)'(NUM_SRC)) scan_sum = scan_sum - (SRC_W+1)'(NUM_SRC);
      scan_idx = scan_sum[SRC_W-1:0];
      clash = 1'b0;
      for (int k = 0; k < NUM_WR_PORTS; k++) begin
        if (((PW+1)'(k) < n_gnt) && (port_addr[k] == head_addr[scan_idx])) clash = 1'b1;
      end
      if (nonempty[scan_idx] && (n_gnt < (PW+1)'(NUM_WR_PORTS)) && !clash) begin
        grant[scan_idx]       = 1'b1;
        port_vld[n_gnt[PW-1:0]]  = 1'b1;
        port_addr[n_gnt[PW-1:0]] = head_addr[scan_idx];
        port_data[n_gnt[PW-1:0]] = head_data[scan_idx];
        port_strb[n_gnt[PW-1:0]] = head_strb[scan_idx];
        n_gnt   = n_gnt + 1'b1;
        rr_next = (scan_idx == SRC_W'(NUM_SRC-1)) ? '0 : scan_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        rd_ptr[s] <= '0;
        wr_ptr[s] <= '0;
        count[s]  <= '0;
      end
      rr_ptr <= '0;
      wr_en  <= '0;
      for (int p = 0; p < NUM_WR_PORTS; p++) begin
        wr_addr[p] <= '0;
        wr_data[p] <= '0;
        wr_strb[p] <= '0;
      end
    end else begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (push[s])  wr_ptr[s] <= wr_ptr[s] + 1'b1;
        if (grant[s]) rd_ptr[s] <= rd_ptr[s] + 1'b1;
        count[s] <= count[s] + CNT_W'(push[s]) - CNT_W'(grant[s]);
      end
      rr_ptr <= rr_next;
      wr_en  <= port_vld;
      for (int p = 0; p < NUM_WR_PORTS; p++) begin
        wr_addr[p] <= port_addr[p];
        wr_data[p] <= port_data[p];
        wr_strb[p] <= port_strb[p];
      end
    end
  end

  // Payload storage needs no reset: a slot is only read once count says it was written.
  always_ff @(posedge clk) begin
    for (int s = 0; s < NUM_SRC; s++) begin
      if (push[s]) begin
        mem_addr[s][wr_ptr[s]] <= src_addr[s];
        mem_data[s][wr_ptr[s]] <= src_data[s];
        mem_strb[s][wr_ptr[s]] <= src_strb[s];
      end
    end
  end

  assign idle = (nonempty == '0) && (wr_en == '0);

endmodule
